// File: rtl/addsub_serial.sv
`default_nettype none
// ============================================================================
//  Module      : addsub_serial
//  Description : Digit-serial adder/subtractor, DIGIT bits per clock, with a
//                start/busy/done handshake and carry/overflow/zero flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module addsub_serial #(
   parameter int WIDTH = 32,
   parameter int DIGIT = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             co,
   output logic             ovf,
   output logic             zero
);

   localparam int c_n     = WIDTH / DIGIT;
   localparam int c_cnt_w = (c_n > 1) ? $clog2(c_n) : 1;
   localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_n - 1);

   generate
      if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
         $error("addsub_serial: DIGIT must divide WIDTH exactly");
      end
   endgenerate

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t               r_state;
   logic [c_cnt_w-1:0]   r_cnt;
   logic                 r_carry;
   logic [WIDTH-1:0]     r_opa;
   logic [WIDTH-1:0]     r_opb;

   logic [DIGIT:0]       w_sum;
   logic [WIDTH-1:0]     w_result;
   logic                 w_cin_msb;

   assign w_sum = {1'b0, r_opa[DIGIT-1:0]} + {1'b0, r_opb[DIGIT-1:0]}
                + {{DIGIT{1'b0}}, r_carry};

   // Carry into the top bit of the digit recovered from that bit's sum.
   assign w_cin_msb = w_sum[DIGIT-1] ^ r_opa[DIGIT-1] ^ r_opb[DIGIT-1];

   generate
      if (c_n == 1) begin : g_single
         assign w_result = w_sum[DIGIT-1:0];
      end else begin : g_multi
         logic [WIDTH-DIGIT-1:0] r_acc;

         assign w_result = {w_sum[DIGIT-1:0], r_acc};

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_acc <= '0;
            end else if (r_state == ST_RUN) begin
               r_acc <= w_result[WIDTH-1:DIGIT];
            end
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_carry <= 1'b0;
         r_opa   <= '0;
         r_opb   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         s       <= '0;
         co      <= 1'b0;
         ovf     <= 1'b0;
         zero    <= 1'b1;
      end else begin
         done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_opa   <= a;
                  r_opb   <= b ^ {WIDTH{sub}};
                  r_carry <= sub;
                  r_cnt   <= '0;
                  busy    <= 1'b1;
                  r_state <= ST_RUN;
               end
            end
            ST_RUN: begin
               r_opa   <= r_opa >> DIGIT;
               r_opb   <= r_opb >> DIGIT;
               r_carry <= w_sum[DIGIT];
               r_cnt   <= r_cnt + c_cnt_w'(1);
               if (r_cnt == c_last) begin
                  s       <= w_result;
                  co      <= w_sum[DIGIT];
                  ovf     <= w_cin_msb ^ w_sum[DIGIT];
                  zero    <= (w_result == '0);
                  done    <= 1'b1;
                  busy    <= 1'b0;
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire
